// File: rtl/alu_pkg.sv
// Shared ALU command encoding and arbiter state encoding.
package alu_pkg;

    typedef enum logic [3:0] {
        AluAnd  = 4'd0,
        AluOr   = 4'd1,
        AluXor  = 4'd2,
        AluNot  = 4'd3,
        AluAddu = 4'd4,
        AluAdds = 4'd5,
        AluSubu = 4'd6,
        AluSubs = 4'd7,
        AluMulu = 4'd8
    } alu_cmd_e;

    localparam logic [3:0] ALU_CMD_MAX = 4'd8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } alu_arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU: SIZE-bit operands, 2*SIZE-bit zero-extended result, overflow flag.
// Outputs are all-zero when disabled or when the command is not recognised.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned SIZE = 4
) (
    input  logic                enable,
    input  logic [3:0]          cmd,
    input  logic [SIZE-1:0]     a,
    input  logic [SIZE-1:0]     b,
    output logic [2*SIZE-1:0]   result,
    output logic                overflow
);

    logic [SIZE:0]     sum;
    logic [SIZE:0]     diff;
    logic [2*SIZE-1:0] prod;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign prod = {{SIZE{1'b0}}, a} * {{SIZE{1'b0}}, b};

    // Add/sub keep only SIZE bits; carry, borrow or signed overflow goes to the flag.
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        if (enable) begin
            case (cmd)
                AluAnd:  result[SIZE-1:0] = a & b;
                AluOr:   result[SIZE-1:0] = a | b;
                AluXor:  result[SIZE-1:0] = a ^ b;
                AluNot:  result[SIZE-1:0] = ~a;
                AluAddu: begin
                    result[SIZE-1:0] = sum[SIZE-1:0];
                    overflow         = sum[SIZE];
                end
                AluAdds: begin
                    result[SIZE-1:0] = sum[SIZE-1:0];
                    overflow         = (a[SIZE-1] == b[SIZE-1]) && (sum[SIZE-1] != a[SIZE-1]);
                end
                AluSubu: begin
                    result[SIZE-1:0] = diff[SIZE-1:0];
                    overflow         = diff[SIZE];
                end
                AluSubs: begin
                    result[SIZE-1:0] = diff[SIZE-1:0];
                    overflow         = (a[SIZE-1] != b[SIZE-1]) && (diff[SIZE-1] != a[SIZE-1]);
                end
                AluMulu: begin
                    result   = prod;
                    overflow = |prod[2*SIZE-1:SIZE];
                end
                default: begin
                    result   = '0;
                    overflow = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter sharing one alu, with a registered, back-pressured response.
// Define ALU_ARB_ILLEGAL_CHECK_EN to flag commands above ALU_CMD_MAX via rsp_err.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned SIZE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [3:0]          req_cmd0,
    input  logic [3:0]          req_cmd1,
    input  logic [SIZE-1:0]     req_a0,
    input  logic [SIZE-1:0]     req_a1,
    input  logic [SIZE-1:0]     req_b0,
    input  logic [SIZE-1:0]     req_b1,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [2*SIZE-1:0]   rsp_result,
    output logic                rsp_overflow,
    output logic                rsp_err
);

    localparam logic [1:0] IDLE = StIdle;
    localparam logic [1:0] EXEC = StExec;
    localparam logic [1:0] RESP = StResp;

    logic [1:0]          state_q, state_d;
    logic                last_q;
    logic [3:0]          cmd_q;
    logic [SIZE-1:0]     a_q, b_q;
    logic                id_q, err_q;
    logic [1:0]          grant;
    logic                sel;
    logic [3:0]          sel_cmd;
    logic                sel_err;
    logic                alu_en;
    logic [2*SIZE-1:0]   alu_result;
    logic                alu_ovf;
    logic [2*SIZE-1:0]   result_q;
    logic                ovf_q, rsp_err_q, rsp_id_q;

    // On a tie the port that was not served last wins.
    always_comb begin
        grant = 2'b00;
        if (state_q == IDLE && !rst) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign sel       = grant[1];
    assign sel_cmd   = sel ? req_cmd1 : req_cmd0;

`ifdef ALU_ARB_ILLEGAL_CHECK_EN
    assign sel_err = (sel_cmd > ALU_CMD_MAX);
`else
    assign sel_err = 1'b0;
`endif

    assign alu_en = (state_q == EXEC) && !err_q;

    alu #(
        .SIZE (SIZE)
    ) u_alu (
        .enable   (alu_en),
        .cmd      (cmd_q),
        .a        (a_q),
        .b        (b_q),
        .result   (alu_result),
        .overflow (alu_ovf)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|grant) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cmd_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= 1'b0;
            err_q     <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            rsp_err_q <= 1'b0;
            rsp_id_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && |grant) begin
                last_q <= sel;
                id_q   <= sel;
                cmd_q  <= sel_cmd;
                a_q    <= sel ? req_a1 : req_a0;
                b_q    <= sel ? req_b1 : req_b0;
                err_q  <= sel_err;
            end
            if (state_q == EXEC) begin
                result_q  <= alu_result;
                ovf_q     <= alu_ovf;
                rsp_err_q <= err_q;
                rsp_id_q  <= id_q;
            end
        end
    end

    assign rsp_valid    = (state_q == RESP);
    assign rsp_id       = rsp_id_q;
    assign rsp_result   = result_q;
    assign rsp_overflow = ovf_q;
    assign rsp_err      = rsp_err_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port, round-robin arbiter that shares one instance of the combinational `alu` datapath between two requesters. It provides a valid/ready request handshake per port and one shared, back-pressured response channel tagged with the requester ID. Operands are registered before the ALU and results are registered after it, so the ALU never sees unstable inputs. The block sits between the instruction-issue logic and the ALU.

## Interface
- `SIZE`, 4: operand width; result width is `2*SIZE`.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `req_valid`  in  2: per-port request valid; bit i is port i.
- `req_ready`  out  2: per-port request accept.
- `req_cmd0`, `req_cmd1`  in  4 each: ALU command per port.
- `req_a0`, `req_a1`, `req_b0`, `req_b1`  in  SIZE each: operands per port.
- `rsp_valid`  out  1: response valid.
- `rsp_ready`  in  1: response consumer accept.
- `rsp_id`  out  1: port that issued the response.
- `rsp_result`  out  2*SIZE: registered ALU result.
- `rsp_overflow`  out  1: registered ALU overflow.
- `rsp_err`  out  1: illegal-command flag (see Configuration).

## Operation
- States: IDLE, EXEC, RESP.
- **IDLE**
  - `req_ready[i] = grant[i]`. The grant is combinational from `req_valid` and `last`.
  - If only one port is valid, that port is granted.
  - If both ports are valid, the port not equal to `last` is granted.
  - On handshake, latch cmd/a/b/id, set `last` to the granted port, and go to EXEC.
- **EXEC**
  - ALU `enable` is 1 with the latched cmd/a/b. `enable` is 0 in every other state.
  - At the end of the cycle, capture `result`, `overflow` and the error flag into the response registers, then go to RESP.
- **RESP**
  - `rsp_valid` is 1. Response fields are held stable until `rsp_valid && rsp_ready`, then go to IDLE.
  - `req_ready` is 0 in EXEC and RESP.
- Commands: 0 AND, 1 OR, 2 XOR, 3 NOT(a), 4 ADDU, 5 ADDS, 6 SUBU, 7 SUBS, 8 MULU. Values 9–15 are illegal.
- Arithmetic width: result and overflow are exactly what `alu` produces. The arbiter does no re-extension or truncation.
- Reset behaviour:
  - Reset values: `rsp_valid=0`, `rsp_id=0`, `rsp_result=0`, `rsp_overflow=0`, `rsp_err=0`, `req_ready=0` until reset is released, state IDLE, `last=1` (port 0 wins the first tie).
  - Reset mid-transaction abandons the operation. No response is produced and the requester must re-issue.
- A port that drops `req_valid` before it is granted loses nothing; no state is held for it.

## Timing
- Latency from request handshake (cycle N) to `rsp_valid` is N+2.
- Minimum occupancy is 3 cycles per operation; the next grant comes one cycle after the response handshake, at the earliest.
- If `rsp_ready` is held high, the response is accepted in its first RESP cycle.
- `req_ready` depends combinationally on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- Simultaneous requests with `rsp_ready` held high serve alternately: 0, 1, 0, 1…
- A port holding `req_valid` is served within two operations. The arbiter is starvation-free.

## Configuration
- `ALU_ARB_ILLEGAL_CHECK_EN`
  - Defined: cmd > 8 is decoded in IDLE. EXEC keeps ALU `enable` at 0, and the response has `rsp_err=1`, `rsp_result=0`, `rsp_overflow=0`, with the same latency.
  - Undefined: the command is passed to the ALU unchecked and `rsp_err` is tied to 0.

## Structure
- Shared package `alu_pkg`:
  - `alu_cmd_e` command enum (values above) and `ALU_CMD_MAX = 8`.
  - `alu_arb_state_e` (IDLE/EXEC/RESP).
- Sub-module: one instance of the existing `alu` (`#(SIZE)`). Arbitration, FSM and the response registers stay inline.

## Test plan
- Reset released, port 0 issues AND a=0xA b=0x5 -> `rsp_valid` 2 cycles after handshake, id=0, result=0x00, ovf=0.
- Both ports valid together: port 0 MULU 7*8, port 1 SUBS 0-7 -> first response id=0, result=0x38, ovf=1; second response id=1, result=0x09, ovf=0.
- Both ports valid continuously for 6 operations -> grant order 0,1,0,1,0,1 and no `req_ready` outside IDLE.
- Port 1 ADDS a=0x7 b=0x1, `rsp_ready` held low for 5 cycles -> `rsp_valid` and result=0x08, ovf=1 stable throughout; completes on the `rsp_ready` edge.
- `rst` asserted during EXEC -> `rsp_valid`=0 immediately and state IDLE; the next tie grants port 0.
- With `ALU_ARB_ILLEGAL_CHECK_EN`, cmd=0xC -> `rsp_err`=1, result=0, ovf=0, latency unchanged.
